// File: rtl/fifo_acc_if.sv
// rtl/fifo_acc_if.sv - command, upstream FIFO and result signals of the fifo_acc accumulator
interface fifo_acc_if;
    logic        start;
    logic [3:0]  len;
    logic        abort;
    logic [3:0]  data_count;
    logic        fifo_wr_en;
    logic [31:0] din;
    logic        rd_en;
    logic [31:0] sum;
    logic        ovf;
    logic        busy;
    logic        done;

    // Controller side: issues commands, owns the upstream FIFO, observes results.
    modport master (
        output start, len, abort, data_count, fifo_wr_en, din,
        input  rd_en, sum, ovf, busy, done
    );

    // Accumulator side.
    modport slave (
        input  start, len, abort, data_count, fifo_wr_en, din,
        output rd_en, sum, ovf, busy, done
    );
endinterface

// File: rtl/fifo_acc.sv
// rtl/fifo_acc.sv - pops up to eight words from an upstream FIFO and accumulates them
module fifo_acc (
    input  logic     clk,
    input  logic     reset,
    fifo_acc_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  rem;
    logic        pend;
    logic [31:0] sum_q;
    logic        ovf_q;
    logic        done_q;
    logic        rd;
    logic        accept;
    logic [3:0]  len_sat;
    logic [32:0] add_full;

    // Lengths above eight would overrun the 8-deep FIFO, so they saturate.
    assign len_sat  = (bus.len > 4'd8) ? 4'd8 : bus.len;
    assign accept   = (state == IDLE) && bus.start && !bus.abort;
    assign add_full = {1'b0, sum_q} + {1'b0, bus.din};

    // Next-state and pop decision; a pop is never issued while the FIFO is
    // being written because the FIFO would turn the pair into a no-op.
    always_comb begin
        state_nx = state;
        rd       = 1'b0;
        case (state)
            IDLE: begin
                if (accept && (len_sat != 4'd0)) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_nx = IDLE;
                end else begin
                    rd = (rem != 4'd0) && (bus.data_count != 4'd0) && !bus.fifo_wr_en;
                    if (rd && (rem == 4'd1)) begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (reset) begin
            rd       = 1'b0;
            state_nx = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Word counter, in-flight flag and accumulator; the word arriving in the
    // cycle after a pop is added unless the operation is being aborted.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem    <= 4'd0;
            pend   <= 1'b0;
            sum_q  <= 32'd0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            pend   <= rd;
            if (rd) begin
                rem <= rem - 4'd1;
            end
            if (accept) begin
                sum_q <= 32'd0;
                ovf_q <= 1'b0;
                rem   <= len_sat;
                if (len_sat == 4'd0) begin
                    done_q <= 1'b1;
                end
            end else if (pend && !bus.abort) begin
                sum_q <= add_full[31:0];
                ovf_q <= ovf_q | add_full[32];
            end
            if ((state == DRAIN) && !bus.abort) begin
                done_q <= 1'b1;
            end
        end
    end

    assign bus.rd_en = rd;
    assign bus.sum   = sum_q;
    assign bus.ovf   = ovf_q;
    assign bus.busy  = (state != IDLE);
    assign bus.done  = done_q;
endmodule

// File: tb/tb_fifo_acc.sv
// tb/tb_fifo_acc.sv - randomized scoreboard bench for fifo_acc with an upstream FIFO model
module tb_fifo_acc;
    typedef struct {
        logic [31:0] sum;
        logic        ovf;
        int          pops;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wdata;
    logic        flush;
    logic        rd_s;
    logic        wr_s;
    logic [31:0] wd_s;
    logic [31:0] fq[$];
    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    fifo_acc_if bus ();

    fifo_acc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture the FIFO-side requests in mid-cycle so the edge update is race free.
    always @(negedge clk) begin
        rd_s <= bus.rd_en;
        wr_s <= bus.fifo_wr_en;
        wd_s <= wdata;
    end

    // Upstream 8-deep FIFO: simultaneous write and read is a no-op.
    always @(posedge clk) begin
        if (flush) begin
            fq.delete();
        end else if (wr_s && !rd_s) begin
            fq.push_back(wd_s);
        end else if (rd_s && !wr_s) begin
            bus.din <= fq.pop_front();
        end
        bus.data_count <= 4'(fq.size());
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: sum of the first min(len,8) words modulo 2^32, ovf if any add carried.
    function automatic exp_t model(input logic [31:0] w[$], input int len, input int lat);
        exp_t        e;
        logic [32:0] t;
        int          n;
        n     = (len > 8) ? 8 : len;
        e.sum = 32'd0;
        e.ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            t     = {1'b0, e.sum} + {1'b0, w[i]};
            e.sum = t[31:0];
            e.ovf = e.ovf | t[32];
        end
        e.pops = n;
        e.lat  = lat;
        return e;
    endfunction

    task automatic monitor();
        int   pops = 0;
        int   start_c = 0;
        int   last_pop = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                pops = 0;
            end else begin
                if (bus.rd_en) begin
                    chk("rd_en_legal", {61'd0, bus.fifo_wr_en, bus.data_count == 4'd0, !bus.busy}, 64'd0);
                    pops++;
                    last_pop = cyc;
                end
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("sum", bus.sum, e.sum);
                        chk("ovf", bus.ovf, e.ovf);
                        chk("pop_count", pops, e.pops);
                        if (e.lat >= 0) chk("done_latency", cyc - start_c, e.lat);
                        if (e.pops > 0) chk("done_after_last_pop", cyc - last_pop, 2);
                    end
                end
                if (bus.start && !bus.abort && !bus.busy) begin
                    pops = 0;
                    start_c = cyc;
                end
            end
        end
    endtask

    task automatic wr(input logic [31:0] word, input bit st);
        bus.fifo_wr_en = 1'b1;
        wdata = word;
        bus.start = st;
        tick();
        bus.fifo_wr_en = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!bus.busy) break;
            tick();
        end
        if (bus.busy) begin
            chk("idle_timeout", 64'd1, 64'd0);
            reset = 1'b1;
            tick();
            reset = 1'b0;
        end
        tick();
        tick();
        chk("done_seen", sb.size(), 64'd0);
        chk("fifo_drained", bus.data_count, 64'd0);
        sb.delete();
        do_flush();
    endtask

    task automatic issue_start(input int len);
        bus.start = 1'b1;
        bus.len = 4'(len);
        tick();
        bus.start = 1'b0;
        bus.len = 4'($urandom);
    endtask

    task automatic run_op(input logic [31:0] w[$], input int len, input int pre, input bit rnd);
        int n = (len > 8) ? 8 : len;
        int lat = (pre >= n) ? ((n == 0) ? 1 : n + 2) : -1;
        sb.push_back(model(w, len, lat));
        for (int i = 0; i < pre; i++) wr(w[i], 1'b0);
        issue_start(len);
        for (int i = pre; i < n; i++) begin
            if (rnd) repeat ($urandom_range(0, 3)) tick();
            wr(w[i], rnd && ($urandom_range(0, 3) == 0));
        end
        wait_idle();
    endtask

    task automatic stop_test(input bit use_reset);
        logic [31:0] w[$];
        exp_t        e;
        for (int i = 0; i < 5; i++) w.push_back($urandom);
        for (int i = 0; i < 5; i++) wr(w[i], 1'b0);
        issue_start(5);
        tick();
        tick();
        if (use_reset) reset = 1'b1;
        else bus.abort = 1'b1;
        #1;
        chk("stop_rd_en_low", bus.rd_en, 64'd0);
        tick();
        reset = 1'b0;
        bus.abort = 1'b0;
        chk("stop_busy", bus.busy, 64'd0);
        repeat (4) tick();
        e = model(w, 1, -1);
        chk("stop_sum", bus.sum, use_reset ? 64'd0 : 64'(e.sum));
        chk("stop_ovf", bus.ovf, 64'd0);
        chk("stop_done", bus.done, 64'd0);
        do_flush();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        logic [31:0] w[$];
        int          len;
        int          n;
        bus.start = 1'b0;
        bus.len = 4'd0;
        bus.abort = 1'b0;
        bus.fifo_wr_en = 1'b0;
        wdata = 32'd0;
        flush = 1'b1;
        reset = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) tick();
        chk("reset_sum", bus.sum, 64'd0);
        chk("reset_ovf", bus.ovf, 64'd0);
        chk("reset_busy", bus.busy, 64'd0);
        chk("reset_done", bus.done, 64'd0);
        chk("reset_rd_en", bus.rd_en, 64'd0);
        reset = 1'b0;
        flush = 1'b0;
        tick();

        // Nominal 3,5,7,9.
        w = '{32'd3, 32'd5, 32'd7, 32'd9};
        run_op(w, 4, 4, 1'b0);

        // Empty stall, then two late writes.
        w = '{32'd100, 32'd23};
        sb.push_back(model(w, 2, -1));
        issue_start(2);
        repeat (5) tick();
        chk("stall_busy", bus.busy, 64'd1);
        wr(w[0], 1'b0);
        repeat (2) tick();
        wr(w[1], 1'b0);
        wait_idle();

        // Write collision on the second pop.
        w = '{32'd11, 32'd22, 32'd33, 32'd44};
        sb.push_back(model(w, 4, 7));
        for (int i = 0; i < 3; i++) wr(w[i], 1'b0);
        issue_start(4);
        tick();
        bus.fifo_wr_en = 1'b1;
        wdata = w[3];
        #1;
        chk("collision_rd_en", bus.rd_en, 64'd0);
        tick();
        bus.fifo_wr_en = 1'b0;
        wait_idle();

        // Overflow.
        w = '{32'hFFFF_FFFF, 32'h0000_0002};
        run_op(w, 2, 2, 1'b0);

        // start together with abort in IDLE: nothing happens, results hold.
        wr(32'd5, 1'b0);
        bus.abort = 1'b1;
        issue_start(1);
        bus.abort = 1'b0;
        repeat (3) tick();
        chk("idle_abort_busy", bus.busy, 64'd0);
        chk("idle_abort_sum", bus.sum, 64'd1);
        chk("idle_abort_ovf", bus.ovf, 64'd1);
        chk("idle_abort_count", bus.data_count, 64'd1);
        do_flush();

        // len=0 and saturated len=12.
        w.delete();
        run_op(w, 0, 0, 1'b0);
        for (int i = 0; i < 8; i++) w.push_back($urandom);
        run_op(w, 12, 8, 1'b0);

        stop_test(1'b0);
        stop_test(1'b1);

        // Randomized operations.
        for (int k = 0; k < 30; k++) begin
            len = $urandom_range(0, 15);
            n = (len > 8) ? 8 : len;
            w.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 2) == 0) w.push_back(32'hF000_0000 | $urandom);
                else w.push_back($urandom_range(0, 1000));
            end
            run_op(w, len, $urandom_range(0, n), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_acc.md
FIFO_ACC -- requirements
Module: fifo_acc

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk  input  1  clock; every flop samples on the rising edge.
REQ-003 Port reset  input  1  synchronous active-high reset.
REQ-004 Port start  input  1  one-cycle request to begin an accumulation; sampled only in IDLE.
REQ-005 Port len  input  4  number of words to consume; sampled with start; legal range 0..8; 9..15 are treated as 8.
REQ-006 Port abort  input  1  terminates the current operation; takes priority over start.
REQ-007 Port data_count  input  4  occupancy of the upstream 8-deep FIFO; 0..8.
REQ-008 Port fifo_wr_en  input  1  the upstream FIFO's write enable for this cycle, which the block monitors.
REQ-009 Port din  input  32  upstream FIFO read data; valid in the cycle after a cycle with rd_en=1.
REQ-010 Port rd_en  output  1  FIFO pop request; combinational.
REQ-011 Port sum  output  32  accumulated result; registered.
REQ-012 Port ovf  output  1  sticky carry-out of the current operation; registered.
REQ-013 Port busy  output  1  high in every state except IDLE; registered state decode.
REQ-014 Port done  output  1  one-cycle completion pulse; registered.

Function
REQ-015 The state machine SHALL have three states: IDLE, RUN and DRAIN, encoded 2'b00, 2'b01 and 2'b10.
REQ-016 IDLE behaviour:
  - start=1 and abort=0 SHALL clear sum and ovf and load rem <- min(len,8).
  - Next state SHALL be RUN if the loaded rem is nonzero.
  - If the loaded rem is zero, the block SHALL pulse done the next cycle with sum=0 and stay in IDLE.
REQ-017 rd_en SHALL be 1 only when all of the following hold: state=RUN, rem!=0, data_count!=0, fifo_wr_en=0, reset=0 and abort=0.
REQ-018 The fifo_wr_en=0 condition exists because the FIFO treats a simultaneous write and read as a no-op; the block SHALL never pop in a cycle where the FIFO is writing.
REQ-019 Each cycle with rd_en=1 SHALL decrement rem (4-bit) and set the in-flight flag pend for the next cycle.
REQ-020 In each cycle with pend=1, sum SHALL take sum+din modulo 2^32, and ovf SHALL be set if the 33-bit carry is 1.
REQ-021 While an operation is active, ovf SHALL never clear.
REQ-022 RUN SHALL go to DRAIN on the edge where rem reaches 0.
REQ-023 DRAIN SHALL last exactly one cycle: it absorbs the final pend word, then returns to IDLE with done=1 in the following cycle.
REQ-024 Throughput SHALL be one word per cycle while the FIFO is non-empty and not being written.
REQ-025 With the FIFO continuously ready, done SHALL rise len+2 cycles after the start cycle, for len 1..8.
REQ-026 While the FIFO is empty in RUN, rd_en SHALL be 0 and the state SHALL be held; there is no timeout.
REQ-027 If the FIFO is written in a cycle, rd_en SHALL be 0 that cycle and the pop SHALL retry in the next cycle.
REQ-028 abort=1 in RUN or DRAIN SHALL:
  - force rd_en=0 in that cycle;
  - go to IDLE on the next edge;
  - discard any pend word;
  - not pulse done;
  - hold sum and ovf at their partial values.
REQ-029 start SHALL be ignored outside IDLE.
REQ-030 abort in IDLE SHALL have no effect.
REQ-031 len is captured only with start; later changes to len SHALL be ignored.

Reset
REQ-032 reset=1 at a rising edge SHALL give state=IDLE, rem=0, pend=0, sum=0, ovf=0 and done=0, and busy=0.
REQ-033 While reset=1, rd_en SHALL be 0 combinationally.
REQ-034 A reset asserted mid-operation SHALL discard the in-flight word, and done SHALL not be pulsed.
REQ-035 Reset SHALL take priority over abort and start.

Verification
REQ-036 Nominal: FIFO holds 3,5,7,9 (data_count=4); start with len=4 -> rd_en high for 4 consecutive cycles; done pulses at cycle 6 after start; sum=24; ovf=0; data_count ends at 0.
REQ-037 Empty stall: data_count=0; start with len=2 -> rd_en stays 0 and busy stays 1; two words written later -> two pops; sum equals their total; done 2 cycles after the last pop.
REQ-038 Write collision: fifo_wr_en=1 in the cycle the second pop would occur -> rd_en=0 that cycle and the pop occurs in the next cycle; sum still correct; the FIFO never enters its no-op from a simultaneous write and read.
REQ-039 Overflow: words 0xFFFF_FFFF and 0x0000_0002 with len=2 -> sum=0x0000_0001 and ovf=1.
REQ-040 len=0 -> no rd_en; done in the next cycle with sum=0. len=12 -> exactly 8 pops.
REQ-041 Abort/reset: abort asserted after 2 pops of 5 -> IDLE next cycle; no done; sum equals the first word only; the in-flight second word is discarded. Repeat with reset instead -> all outputs return to 0.
